// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative restoring divider, one quotient bit per cycle (MSB first).
// Start/done handshake; results are held until the next accepted start.
// Optional macro DIV_SIGNED_EN: two's-complement operands. The unsigned core runs on
// magnitudes and the signs are fixed up on entry to DONE.
// Requires WIDTH >= 2.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  // Dividend bits shift out at the MSB while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             div_zero;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

  logic [WIDTH:0]   trial, nb, p_vec, g_vec;
  logic [WIDTH-1:0] diff;
  logic             carry, ge;
  logic [WIDTH-1:0] q_new, r_new, q_fix, r_fix;

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;
`endif

  assign accept   = start && (state_q != StRun);
  assign div_zero = (divisor == '0);

  // Operand magnitudes fed into the unsigned core
  always_comb begin
`ifdef DIV_SIGNED_EN
    dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    dvs_mag = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
`else
    dvd_mag = dividend;
    dvs_mag = divisor;
`endif
  end

  // Trial subtract r' - divisor on WIDTH+1 bits with P/G carry chain; carry out means r' >= d
  always_comb begin
    trial = {r_q, dq_q[WIDTH-1]};
    nb    = ~{1'b0, dvs_q};
    p_vec = trial ^ nb;
    g_vec = trial & nb;
    carry = 1'b1;
    diff  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = p_vec[i] ^ carry;
      carry   = g_vec[i] | (p_vec[i] & carry);
    end
    ge    = g_vec[WIDTH] | (p_vec[WIDTH] & carry);
    // A restored or reduced remainder is always below the divisor, so WIDTH bits suffice.
    r_new = ge ? diff : trial[WIDTH-1:0];
    q_new = {dq_q[WIDTH-2:0], ge};
  end

  // Sign fix-up applied to the final iteration's result
  always_comb begin
`ifdef DIV_SIGNED_EN
    q_fix = neg_q_q ? (~q_new + WIDTH'(1)) : q_new;
    r_fix = neg_r_q ? (~r_new + WIDTH'(1)) : r_new;
`else
    q_fix = q_new;
    r_fix = r_new;
`endif
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) state_d = div_zero ? StDone : StRun;
        else        state_d = StIdle;
      end
      StRun: begin
        if (count_q == '0) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: operand capture, iteration, result load on entry to DONE
  always_comb begin
    count_d     = count_q;
    dq_d        = dq_q;
    r_d         = r_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif
    if (accept) begin
      if (div_zero) begin
        quotient_d  = '1;
        remainder_d = dividend;
        dbz_d       = 1'b1;
      end else begin
        dq_d    = dvd_mag;
        dvs_d   = dvs_mag;
        r_d     = '0;
        count_d = CntW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
        neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r_d = dividend[WIDTH-1];
`endif
      end
    end else if (state_q == StRun) begin
      dq_d = q_new;
      r_d  = r_new;
      if (count_q == '0) begin
        quotient_d  = q_fix;
        remainder_d = r_fix;
        dbz_d       = 1'b0;
      end else begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      dq_q        <= '0;
      r_q         <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dq_q        <= dq_d;
      r_q         <= r_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    busy        = (state_q == StRun);
    done        = (state_q == StDone);
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

endmodule
